// File: rtl/song_select_ctrl_pkg.sv
// song_select_ctrl_pkg: button indices, default sizes and step direction type for the song selector
package song_select_ctrl_pkg;
  localparam int BTN_PREV = 0;
  localparam int BTN_CONFIRM = 1;
  localparam int BTN_NEXT = 2;
  localparam int DEF_DEBOUNCE_CYC = 65536;
  localparam int DEF_NUM_SONGS = 4;
  typedef enum logic [1:0] {STEP_NONE, STEP_DN, STEP_UP} step_e;
endpackage

// File: rtl/song_select_ctrl_btn_debounce.sv
// btn_debounce: 2-flop sync + hold counter (clk, rst, raw in; accepted level, one-cycle press out)
module btn_debounce
  import song_select_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      level_d <= 1'b0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      level_d <= level;
      press <= level & ~level_d;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= ~level;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/song_select_ctrl.sv
// song_select_ctrl: debounced prev/confirm/next buttons -> song_num with wrap/saturate, auto-repeat, song_chg/play_req strobes, at_limit
module song_select_ctrl
  import song_select_ctrl_pkg::*;
#(
  parameter int NUM_SONGS = DEF_NUM_SONGS,
  parameter int SEL_W = $clog2(NUM_SONGS),
  parameter int INIT_SONG = 0,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int WRAP = 1,
  parameter int AUTO_REPEAT = 1,
  parameter int RPT_DELAY = 2**22,
  parameter int RPT_RATE = 2**20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       button,
  output logic [SEL_W-1:0] song_num,
  output logic             song_chg,
  output logic             play_req,
  output logic             at_limit
);
  localparam int RMAX = RPT_DELAY > RPT_RATE ? RPT_DELAY : RPT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [SEL_W-1:0] MAX = SEL_W'(NUM_SONGS - 1);
  localparam logic [SEL_W-1:0] INIT = SEL_W'(INIT_SONG);
  logic [2:0] level, press, tick, first, ev;
  logic [RW-1:0] rpt_cnt [3];
  step_e step;
  logic [SEL_W-1:0] nxt;
  for (genvar g = 0; g < 3; g++) begin : g_ch
    localparam bit REP = AUTO_REPEAT != 0 && g != BTN_CONFIRM;
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk(clk),
      .rst(rst),
      .raw(button[g]),
      .level(level[g]),
      .press(press[g])
    );
    assign tick[g] = REP && level[g] && rpt_cnt[g] == (first[g] ? RW'(RPT_DELAY) : RW'(RPT_RATE));
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rpt_cnt[g] <= '0;
        first[g] <= 1'b0;
      end else if (!level[g]) rpt_cnt[g] <= '0;
      else if (press[g] && REP) begin
        rpt_cnt[g] <= RW'(1);
        first[g] <= 1'b1;
      end else if (tick[g]) begin
        rpt_cnt[g] <= RW'(1);
        first[g] <= 1'b0;
      end else if (rpt_cnt[g] != '0) rpt_cnt[g] <= rpt_cnt[g] + 1'b1;
  end
  assign ev = press | tick;
  always_comb begin
    step = ev[BTN_PREV] == ev[BTN_NEXT] ? STEP_NONE : ev[BTN_NEXT] ? STEP_UP : STEP_DN;
    nxt = step == STEP_UP ? (song_num == MAX ? (WRAP != 0 ? '0 : song_num) : song_num + 1'b1) :
          step == STEP_DN ? (song_num == '0 ? (WRAP != 0 ? MAX : song_num) : song_num - 1'b1) :
          song_num;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      song_num <= INIT;
      song_chg <= 1'b0;
      play_req <= 1'b0;
      at_limit <= WRAP == 0 && (INIT == '0 || INIT == MAX);
    end else begin
      song_num <= nxt;
      song_chg <= nxt != song_num;
      play_req <= ev[BTN_CONFIRM];
      at_limit <= WRAP == 0 && (nxt == '0 || nxt == MAX);
    end
endmodule

// File: tb/tb_song_select_ctrl.sv
// tb_song_select_ctrl: scoreboard bench for a wrapping auto-repeat selector and a saturating single-step selector
module tb_song_select_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] btn_r = '0, btn_s = '0;
  logic [2:0] num_r, num_s;
  logic chg_r, chg_s, play_r, play_s, lim_r, lim_s;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int t0;
  typedef struct {int c; int v;} ev_t;
  ev_t q_r[$], q_s[$], q_p[$];
  ev_t e_r, e_s, e_p;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  song_select_ctrl #(.NUM_SONGS(5), .DEBOUNCE_CYC(4), .WRAP(1), .AUTO_REPEAT(1), .RPT_DELAY(10), .RPT_RATE(3)) u_rep (
    .clk(clk), .rst(rst), .button(btn_r), .song_num(num_r), .song_chg(chg_r), .play_req(play_r), .at_limit(lim_r)
  );
  song_select_ctrl #(.NUM_SONGS(5), .DEBOUNCE_CYC(4), .WRAP(0), .AUTO_REPEAT(0), .RPT_DELAY(10), .RPT_RATE(3)) u_sat (
    .clk(clk), .rst(rst), .button(btn_s), .song_num(num_s), .song_chg(chg_s), .play_req(play_s), .at_limit(lim_s)
  );
  task automatic cmp(input string nm, input int act_c, input int act_v, input int exp_c, input int exp_v);
    n_chk++;
    if (act_c != exp_c || act_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got cycle %0d song %0d, expected cycle %0d song %0d", nm, act_c, act_v, exp_c, exp_v);
    end
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (chg_r) begin
        if (q_r.size() == 0) cmp("rep unexpected song_chg", cyc, int'(num_r), -1, -1);
        else begin
          e_r = q_r.pop_front();
          cmp("rep song_chg", cyc, int'(num_r), e_r.c, e_r.v);
        end
      end
      if (chg_s) begin
        if (q_s.size() == 0) cmp("sat unexpected song_chg", cyc, int'(num_s), -1, -1);
        else begin
          e_s = q_s.pop_front();
          cmp("sat song_chg", cyc, int'(num_s), e_s.c, e_s.v);
        end
      end
      if (play_r) begin
        if (q_p.size() == 0) cmp("rep unexpected play_req", cyc, int'(num_r), -1, -1);
        else begin
          e_p = q_p.pop_front();
          cmp("rep play_req", cyc, int'(num_r), e_p.c, e_p.v);
        end
      end
      if (play_s) cmp("sat unexpected play_req", cyc, int'(num_s), -1, -1);
    end
  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);
    chk("reset rep song_num", int'(num_r), 0);
    chk("reset sat song_num", int'(num_s), 0);
    chk("reset rep strobes", int'({chg_r, play_r}), 0);
    chk("reset sat at_limit", int'(lim_s), 1);
    chk("reset rep at_limit", int'(lim_r), 0);
    t0 = cyc;
    btn_s = 3'b100;
    q_s.push_back('{t0 + 8, 1});
    idle(20);
    btn_s = '0;
    idle(15);
    chk("sat held next once", int'(num_s), 1);
    chk("sat at_limit mid", int'(lim_s), 0);
    for (int i = 0; i < 4; i++) begin
      btn_s = i[0] ? 3'b000 : 3'b100;
      idle(1);
    end
    btn_s = '0;
    idle(15);
    chk("sat bounce ignored", int'(num_s), 1);
    t0 = cyc;
    btn_s = 3'b001;
    q_s.push_back('{t0 + 8, 0});
    idle(8);
    btn_s = '0;
    idle(15);
    btn_s = 3'b001;
    idle(8);
    btn_s = '0;
    idle(15);
    chk("sat prev at 0 held", int'(num_s), 0);
    chk("sat at_limit at 0", int'(lim_s), 1);
    t0 = cyc;
    btn_r = 3'b001;
    q_r.push_back('{t0 + 8, 4});
    idle(8);
    btn_r = '0;
    idle(15);
    chk("rep wrap 0 to 4", int'(num_r), 4);
    t0 = cyc;
    btn_r = 3'b100;
    q_r.push_back('{t0 + 8, 0});
    idle(8);
    btn_r = '0;
    idle(15);
    chk("rep wrap 4 to 0", int'(num_r), 0);
    t0 = cyc;
    btn_r = 3'b100;
    q_r.push_back('{t0 + 8, 1});
    q_r.push_back('{t0 + 18, 2});
    q_r.push_back('{t0 + 21, 3});
    q_r.push_back('{t0 + 24, 4});
    q_r.push_back('{t0 + 27, 0});
    q_r.push_back('{t0 + 30, 1});
    q_r.push_back('{t0 + 33, 2});
    q_r.push_back('{t0 + 36, 3});
    idle(30);
    btn_r = '0;
    idle(20);
    chk("rep after auto-repeat", int'(num_r), 3);
    btn_r = 3'b101;
    idle(30);
    btn_r = '0;
    idle(20);
    chk("rep prev+next dropped", int'(num_r), 3);
    t0 = cyc;
    btn_r = 3'b010;
    q_p.push_back('{t0 + 8, 3});
    idle(50);
    btn_r = '0;
    idle(15);
    t0 = cyc;
    btn_r = 3'b110;
    q_r.push_back('{t0 + 8, 4});
    q_p.push_back('{t0 + 8, 4});
    idle(8);
    btn_r = '0;
    idle(15);
    t0 = cyc;
    btn_r = 3'b100;
    q_r.push_back('{t0 + 8, 0});
    q_r.push_back('{t0 + 18, 1});
    q_r.push_back('{t0 + 21, 2});
    q_r.push_back('{t0 + 24, 3});
    idle(25);
    chk("rep before reset", int'(num_r), 3);
    rst = 1'b1;
    #1;
    chk("rep async reset song_num", int'(num_r), 0);
    chk("rep async reset strobes", int'({chg_r, play_r}), 0);
    idle(2);
    rst = 1'b0;
    t0 = cyc;
    q_r.push_back('{t0 + 8, 1});
    idle(10);
    btn_r = '0;
    idle(20);
    chk("rep re-debounced after reset", int'(num_r), 1);
    chk("rep song events left", q_r.size(), 0);
    chk("sat song events left", q_s.size(), 0);
    chk("rep play events left", q_p.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
